// File: rtl/reg_file_write_bank.sv
// Write side of the integer register file: one-hot write decode and
// storage for x1..x31, exported flat for the read multiplexers.
module reg_file_write_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h7FFF_EFFC,
    parameter logic [DATA_WIDTH-1:0] GP_RESET   = 32'h1000_8000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [4:0]               write_register,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [32*DATA_WIDTH-1:0] q_bus,
    output logic [31:0]              write_enable
);

    logic [31:0] w_we;

    // x0 is never selected, so a write to index 0 has nowhere to land.
    always_comb begin
        w_we = '0;
        if (reg_write && (write_register != 5'd0)) begin
            w_we[write_register] = 1'b1;
        end
    end

    assign write_enable = w_we;

    assign q_bus[0 +: DATA_WIDTH] = '0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] RST_VAL =
            (i == 2) ? SP_RESET : ((i == 3) ? GP_RESET : '0);

        logic [DATA_WIDTH-1:0] r_x;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_x <= RST_VAL;
            end else if (w_we[i]) begin
                r_x <= write_data;
            end
        end

        assign q_bus[i*DATA_WIDTH +: DATA_WIDTH] = r_x;
    end

endmodule

// File: tb/tb_reg_file_write_bank.sv
// Directed bench for reg_file_write_bank: reset values, decode, write latency,
// x0 protection and asynchronous reset behaviour.
module tb_reg_file_write_bank;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;

    logic          clk;
    logic          clk_run;
    logic          reset;
    logic          reg_write;
    logic [4:0]    write_register;
    logic [31:0]   write_data;
    logic [1023:0] q_bus;
    logic [31:0]   write_enable;

    logic [31:0] exp_x [32];
    int n_err;
    int n_chk;

    reg_file_write_bank #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .q_bus          (q_bus),
        .write_enable   (write_enable)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s x%0d", tag, i), q_bus[i*32 +: 32], exp_x[i]);
        end
    endtask

    task automatic exp_reset();
        for (int i = 0; i < 32; i++) exp_x[i] = 32'h0;
        exp_x[2] = SP;
        exp_x[3] = GP;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d);
        reg_write      = we;
        write_register = rd;
        write_data     = d;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        clk_run = 1'b0;
        drive(1'b0, 5'd0, 32'h0);

        // Asynchronous reset with the clock idle
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        exp_reset();
        check_all("rst");
        #2 reset = 1'b1;
        #2;
        check_all("rst_rel");
        check("we_idle", write_enable, 32'h0);

        clk_run = 1'b1;
        tick();

        // Basic write
        drive(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        check("we_x5", write_enable, 32'h0000_0020);
        check("x5_pre", q_bus[5*32 +: 32], 32'h0);
        tick();
        drive(1'b0, 5'd5, 32'hDEAD_BEEF);
        exp_x[5] = 32'hDEAD_BEEF;
        check_all("wr5");

        // x0 protection
        drive(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("we_x0", write_enable, 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check_all("wr0");

        // Strobe low for three edges
        drive(1'b0, 5'd7, 32'h1234_5678);
        #1;
        check("we_off", write_enable, 32'h0);
        tick(); tick(); tick();
        check_all("off7");

        // Back-to-back writes and overwrite
        drive(1'b1, 5'd31, 32'h0000_0001);
        #1;
        check("we_x31", write_enable, 32'h8000_0000);
        tick();
        check("x31_a", q_bus[31*32 +: 32], 32'h0000_0001);
        drive(1'b1, 5'd31, 32'h8000_0000);
        tick();
        drive(1'b1, 5'd1, 32'hAAAA_5555);
        #1;
        check("we_x1", write_enable, 32'h0000_0002);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        exp_x[31] = 32'h8000_0000;
        exp_x[1]  = 32'hAAAA_5555;
        check_all("b2b");

        // x2 is an ordinary register after reset
        drive(1'b1, 5'd2, 32'h0BAD_F00D);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        exp_x[2] = 32'h0BAD_F00D;
        check_all("wr2");

        // Reset mid-operation discards a coincident write
        drive(1'b1, 5'd10, 32'hCAFE_F00D);
        tick();
        check("x10_a", q_bus[10*32 +: 32], 32'hCAFE_F00D);
        drive(1'b1, 5'd10, 32'h1111_1111);
        reset = 1'b0;
        #1;
        exp_reset();
        check_all("rst_mid");
        tick();
        check("x10_rst_edge", q_bus[10*32 +: 32], 32'h0);
        drive(1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        check_all("rst_after");

        // Async reset with the clock stopped right after a write
        drive(1'b1, 5'd4, 32'h0000_0044);
        tick();
        drive(1'b0, 5'd0, 32'h0);
        check("x4_a", q_bus[4*32 +: 32], 32'h0000_0044);
        clk_run = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("x4_async", q_bus[4*32 +: 32], 32'h0);
        check("x2_async", q_bus[2*32 +: 32], SP);
        check("x3_async", q_bus[3*32 +: 32], GP);
        #2 reset = 1'b1;
        #2;
        check_all("rst_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_write_bank.md
Name: reg_file_write_bank

Overview:
Write side of the integer register file: a 5-bit write address is decoded to a one-hot enable, and the selected 32-bit register among x0..x31 is loaded.
All 32 register values are exported on a flat bus that drives the 32-input read multiplexers.
The block sits in the decode/write-back boundary of the RISC-V core, clocked by the core clock.

Parameters:
DATA_WIDTH, 32, width of each register and of write_data
SP_RESET, 32'h7FFF_EFFC, reset value of x2 (stack pointer)
GP_RESET, 32'h1000_8000, reset value of x3 (global pointer)

Ports:
clk  input  1  core clock, rising-edge active
reset  input  1  asynchronous active-low reset
reg_write  input  1  write strobe from control unit; 1 = write this cycle
write_register  input  5  destination register index (rd)
write_data  input  DATA_WIDTH  value to write
q_bus  output  32*DATA_WIDTH  register contents; xi occupies q_bus[i*DATA_WIDTH +: DATA_WIDTH]
write_enable  output  32  one-hot decoded enable (combinational)

Behaviour:
- Reset is asynchronous and active-low: reset=0 forces, independent of clk, x2=SP_RESET, x3=GP_RESET and every other register=0. This also applies mid-write; a write coincident with reset asserted is discarded.
- Decoder (combinational): write_enable[i]=1 iff reg_write=1 and write_register==i and i!=0. write_enable[0] is always 0. write_enable is all-zero when reg_write=0.
- Register i (1..31): on a rising clk edge with reset=1, load write_data when write_enable[i]=1; otherwise hold.
- x0: constant 0. It has no storage, and writes to index 0 are silently dropped, including when reg_write=1.
- Latency: a write sampled at edge N is visible on q_bus after edge N; a read in the same cycle sees the old value. This block has no write-through bypass; forwarding is the pipeline's responsibility.
- Exactly one register changes per edge at most. Unselected registers never change.
- x2 and x3 are ordinary writable registers after reset; only their reset values differ.
- Full-width writes only. There is no byte masking and no sign or zero extension in this block.
- write_register values are all legal (5 bits). X/Z on reg_write must not corrupt registers when reset=0.
- Implementation: one-hot decoder plus 31 enabled DATA_WIDTH-bit registers (generate loop), with x0 tied to zero.

Test Plan:
- Reset: assert reset=0 mid-cycle with clk idle -> q_bus immediately shows x2=7FFF_EFFC, x3=1000_8000, and all others 0. Release reset -> values hold.
- Basic write: reg_write=1, write_register=5, write_data=DEAD_BEEF, one edge -> x5=DEAD_BEEF and no other register changes. Before the edge, write_enable=32'h0000_0020 and x5 still reads 0.
- x0 protection: reg_write=1, write_register=0, write_data=FFFF_FFFF -> write_enable=0 and x0 stays 0 after the edge.
- Strobe low: reg_write=0, write_register=7, write_data=1234_5678 over 3 edges -> x7 unchanged and write_enable=0.
- Back-to-back and overwrite: write x31=0000_0001, then x31=8000_0000, then x1=AAAA_5555 on consecutive edges -> final x31=8000_0000, x1=AAAA_5555, and x2/x3 still at their reset values.
- Reset mid-operation: write x10=CAFE_F00D, then assert reset together with a write of x10=1111_1111 -> x10=0, and the write is lost after reset is released.
